// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Forwarding select codes, FSM states and a select helper.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Youngest producer wins: EX/MEM beats MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic hit_ex,
        input logic hit_mem
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit_ex) begin
            sel = FWD_EXMEM;
        end else if (hit_mem) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot shadow of in-flight destination registers.
// Slot layout: {valid, is_load, wr_reg}; shifts EX -> MEM -> WB.
module hazard_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic              wr_en_i,
    input  logic [REG_AW-1:0] wr_reg_i,
    input  logic              is_load_i,
    output logic [REG_AW+1:0] ex_o,
    output logic [REG_AW+1:0] mem_o,
    output logic [REG_AW+1:0] wb_o
);

    logic [REG_AW+1:0] ex_q;
    logic [REG_AW+1:0] ex_d;
    logic [REG_AW+1:0] mem_q;
    logic [REG_AW+1:0] wb_q;
    logic              ent_vld;

    // Writes to r0 never create a dependency, so they enter as bubbles.
    assign ent_vld = issue_i && wr_en_i && (wr_reg_i != '0);

    // Build the entry that follows the issued instruction into EX.
    always_comb begin
        ex_d = '0;
        if (ent_vld) begin
            ex_d = {1'b1, is_load_i, wr_reg_i};
        end
    end

    // Advance every slot each cycle; reset clears the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, redirect flush and forwarding control.
// Gates PC, IF/ID and ID/EX around a 5-stage pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [REG_AW+1:0] sb_ex;
    logic [REG_AW+1:0] sb_mem;
    logic [REG_AW+1:0] sb_wb;
    logic              sb_unused;

    logic              ex_vld;
    logic              ex_ld;
    logic [REG_AW-1:0] ex_reg;
    logic              mem_vld;
    logic [REG_AW-1:0] mem_reg;

    logic              rs_ex_hit;
    logic              rt_ex_hit;
    logic              rs_mem_hit;
    logic              rt_mem_hit;
    logic              load_use;
    logic              flushing;
    logic              stall;
    logic              issue;

    state_e            state_q;
    state_e            state_d;
    logic [2:0]        fcnt_q;
    logic [2:0]        fcnt_d;
    logic [1:0]        fwd_a_q;
    logic [1:0]        fwd_a_d;
    logic [1:0]        fwd_b_q;
    logic [1:0]        fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_i   (issue),
        .wr_en_i   (id_wr_en),
        .wr_reg_i  (id_wr_reg),
        .is_load_i (id_is_load),
        .ex_o      (sb_ex),
        .mem_o     (sb_mem),
        .wb_o      (sb_wb)
    );

    // The WB producer has written the RF by the time ID reads it.
    assign sb_unused = ^{sb_mem[REG_AW], sb_wb};

    assign ex_vld  = sb_ex[REG_AW+1];
    assign ex_ld   = sb_ex[REG_AW];
    assign ex_reg  = sb_ex[REG_AW-1:0];
    assign mem_vld = sb_mem[REG_AW+1];
    assign mem_reg = sb_mem[REG_AW-1:0];

    // Valid slots never hold r0, so r0 can never match.
    always_comb begin
        rs_ex_hit  = id_uses_rs && ex_vld  && (ex_reg  == id_rs);
        rt_ex_hit  = id_uses_rt && ex_vld  && (ex_reg  == id_rt);
        rs_mem_hit = id_uses_rs && mem_vld && (mem_reg == id_rs);
        rt_mem_hit = id_uses_rt && mem_vld && (mem_reg == id_rt);
        load_use   = ex_ld && (rs_ex_hit || rt_ex_hit);
        flushing   = (state_q == ST_FLUSH);
        stall      = load_use && !ex_redirect && !flushing;
        issue      = id_valid && !load_use && !flushing && !ex_redirect;
    end

    // Next state and pipeline gating; a redirect overrides everything.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                state_d = ST_RUN;
            end
            ST_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (fcnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d  = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
        if (ex_redirect) begin
            state_d     = ST_FLUSH;
            fcnt_d      = FLUSH_LOAD;
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    // Forward selects follow the instruction into EX; bubbles read RF.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (issue) begin
            fwd_a_d = fwd_sel(rs_ex_hit, rs_mem_hit);
            fwd_b_d = fwd_sel(rt_ex_hit, rt_mem_hit);
        end
    end

    // FSM, flush countdown and forwarding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= 3'd0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ex_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed cases plus random
// instruction streams against an in-flight-instruction model.
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 5;
    localparam int FC   = 2;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic          id_wr_en;
    logic [AW-1:0] id_wr_reg;
    logic          id_is_load;
    logic          ex_redirect;
    logic          pc_write;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_bubble;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    pipeline_hazard_ctrl #(
        .REG_AW       (AW),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_wr_en    (id_wr_en),
        .id_wr_reg   (id_wr_reg),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: the instruction in EX and in MEM (dest writers only),
    // remaining squash cycles, expected selects and event totals.
    typedef struct packed {
        logic          v;
        logic [AW-1:0] r;
        logic          ld;
    } ent_t;

    ent_t m_ex;
    ent_t m_mem;
    int   m_fl;
    int   m_fa;
    int   m_fb;
    int   m_sc;
    int   m_fc;

    function automatic void m_reset();
        m_ex  = '0;
        m_mem = '0;
        m_fl  = 0;
        m_fa  = 0;
        m_fb  = 0;
        m_sc  = 0;
        m_fc  = 0;
    endfunction

    function automatic int src(input logic use_r, input logic [AW-1:0] r);
        if (use_r && m_ex.v && r == m_ex.r) return 1;
        if (use_r && m_mem.v && r == m_mem.r) return 2;
        return 0;
    endfunction

    task automatic drive(input logic v, input int rs, input int rt,
                         input logic urs, input logic urt,
                         input logic we, input int wr,
                         input logic ld, input logic rd);
        id_valid    = v;
        id_rs       = AW'(rs);
        id_rt       = AW'(rt);
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_wr_en    = we;
        id_wr_reg   = AW'(wr);
        id_is_load  = ld;
        ex_redirect = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check gating, advance model, check registered outputs.
    task automatic step();
        bit fl;
        bit hz;
        bit st;
        bit iss;
        logic [3:0] ctl;
        #1;
        fl  = (m_fl > 0);
        hz  = m_ex.v && m_ex.ld &&
              ((id_uses_rs && id_rs == m_ex.r) ||
               (id_uses_rt && id_rt == m_ex.r));
        st  = hz && !ex_redirect && !fl;
        iss = id_valid && !hz && !fl && !ex_redirect;
        if (ex_redirect || fl) ctl = 4'b1111;
        else if (st) ctl = 4'b0001;
        else ctl = 4'b1100;
        chk("ctl", {28'd0, pc_write, ifid_write, ifid_flush, idex_bubble},
            {28'd0, ctl});
        m_fa = iss ? src(id_uses_rs, id_rs) : 0;
        m_fb = iss ? src(id_uses_rt, id_rt) : 0;
        m_mem = m_ex;
        m_ex.v  = iss && id_wr_en && (id_wr_reg != 0);
        m_ex.r  = id_wr_reg;
        m_ex.ld = id_is_load;
        if (ex_redirect) m_fl = FC;
        else if (fl) m_fl = m_fl - 1;
        if (st && m_sc < CMAX) m_sc++;
        if (ex_redirect && m_fc < CMAX) m_fc++;
        @(posedge clk);
        #1;
        chk("fwd_a", 32'(fwd_a), 32'(m_fa));
        chk("fwd_b", 32'(fwd_b), 32'(m_fb));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
        @(negedge clk);
    endtask

    initial begin
        idle();
        m_reset();
        #3;
        chk("rst_ctl", {28'd0, pc_write, ifid_write, ifid_flush, idex_bubble},
            32'hC);
        chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        chk("rst_cnt", {22'd0, stall_cnt, flush_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw $8 then add $9,$8,$8
        drive(1, 0, 0, 0, 0, 1, 8, 1, 0);
        step();
        drive(1, 8, 8, 1, 1, 1, 9, 0, 0);
        step();
        chk("t1_scnt", 32'(stall_cnt), 32'd1);
        step();
        chk("t1_fa", 32'(fwd_a), 32'd2);
        chk("t1_fb", 32'(fwd_b), 32'd2);

        // add $3 then sub $4,$3,$5
        drive(1, 1, 2, 1, 1, 1, 3, 0, 0);
        step();
        drive(1, 3, 5, 1, 1, 1, 4, 0, 0);
        step();
        chk("t2_fa", 32'(fwd_a), 32'd1);
        chk("t2_fb", 32'(fwd_b), 32'd0);

        // load into $0, then read $0 twice
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        step();
        drive(1, 0, 0, 1, 1, 1, 6, 0, 0);
        step();
        chk("t3_pcw", 32'(pc_write), 32'd1);
        chk("t3_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        idle();
        step();
        step();

        // single redirect pulse
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle();
        #1;
        chk("t4_fl1", 32'(ifid_flush), 32'd1);
        step();
        chk("t4_fl2", 32'(ifid_flush), 32'd1);
        step();
        chk("t4_run", 32'(ifid_flush), 32'd0);
        chk("t4_fcnt", 32'(flush_cnt), 32'd1);
        step();

        // redirect and load-use together
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0);
        step();
        drive(1, 7, 1, 1, 0, 1, 10, 0, 1);
        step();
        chk("t5_scnt", 32'(stall_cnt), 32'd1);
        chk("t5_fcnt", 32'(flush_cnt), 32'd2);
        chk("t5_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        idle();
        repeat (3) step();

        // random instruction stream
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 8,
                  $urandom_range(0, 5), $urandom_range(0, 5),
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 5),
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0);
            step();
        end

        // reset in the middle of a flush
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ctl", {28'd0, pc_write, ifid_write, ifid_flush, idex_bubble},
            32'hC);
        chk("t6_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        chk("t6_cnt", {22'd0, stall_cnt, flush_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (3) step();
        drive(1, 0, 0, 0, 0, 1, 8, 1, 0);
        step();
        drive(1, 8, 0, 1, 0, 1, 9, 0, 0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
